// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer: broadcasts input words to the neuron array,
// then captures and serializes the neuron outputs. Optional macro: FC_LAYER_CTRL_RELU_EN.
module fc_layer_ctrl #(
  parameter int WORD_SIZE             = 16,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int LAYER_HEIGHT          = 3
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [WORD_SIZE-1:0]              data_i,
  output logic [WORD_SIZE-1:0]              neuron_data_o,
  output logic [$clog2(PREVIOUS_LAYER_HEIGHT+1)-1:0] mem_addr_o,
  output logic                              sum_en_o,
  output logic                              add_bias_o,
  input  logic [LAYER_HEIGHT*WORD_SIZE-1:0] neuron_data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [WORD_SIZE-1:0]              data_o
);

  // state     | meaning
  // IDLE      | first cycle after reset release
  // LOAD      | accepting input words, mem_addr = word index
  // BIAS      | last accumulate in flight, mem_addr points at the bias entry
  // WAIT_BIAS | add_bias strobe to the neurons
  // CAPTURE   | neuron outputs latched into the buffer on the closing edge
  // OUT       | buffer streamed downstream one word per handshake
  localparam int H  = PREVIOUS_LAYER_HEIGHT;
  localparam int L  = LAYER_HEIGHT;
  localparam int AW = $clog2(H+1);
  localparam int CW = $clog2(L+1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] BIAS      = 3'd2;
  localparam logic [2:0] WAIT_BIAS = 3'd3;
  localparam logic [2:0] CAPTURE   = 3'd4;
  localparam logic [2:0] OUT       = 3'd5;

  logic [2:0]           state;
  logic [AW-1:0]        in_cnt;
  logic [CW-1:0]        out_cnt;
  logic [WORD_SIZE-1:0] nd_q;
  logic                 sum_en_q;
  logic                 add_bias_q;
  logic [WORD_SIZE-1:0] buffer [L];
  logic [WORD_SIZE-1:0] cap    [L];
  logic                 hs;

  assign ready_o       = (state == LOAD);
  assign valid_o       = (state == OUT);
  assign hs            = valid_i & ready_o;
  assign neuron_data_o = nd_q;
  assign sum_en_o      = sum_en_q;
  assign add_bias_o    = add_bias_q;

  always_comb begin
    mem_addr_o = '0;
    if (state == LOAD)      mem_addr_o = in_cnt;
    else if (state == BIAS) mem_addr_o = AW'(H);
  end

  always_comb begin
    for (int n = 0; n < L; n++) begin
`ifdef FC_LAYER_CTRL_RELU_EN
      cap[n] = neuron_data_i[n*WORD_SIZE + WORD_SIZE-1] ? '0 : neuron_data_i[n*WORD_SIZE +: WORD_SIZE];
`else
      cap[n] = neuron_data_i[n*WORD_SIZE +: WORD_SIZE];
`endif
    end
  end

  always_comb begin
    data_o = '0;
    for (int n = 0; n < L; n++) begin
      if (out_cnt == CW'(n)) data_o = buffer[n];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      nd_q       <= '0;
      sum_en_q   <= 1'b0;
      add_bias_q <= 1'b0;
    end else begin
      sum_en_q   <= hs;
      add_bias_q <= (state == BIAS);
      // the broadcast word is cleared for the bias cycle so neurons see no stale data
      if (hs)                 nd_q <= data_i;
      else if (state == BIAS) nd_q <= '0;

      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          if (hs) begin
            if (in_cnt == AW'(H-1)) begin
              in_cnt <= '0;
              state  <= BIAS;
            end else begin
              in_cnt <= in_cnt + AW'(1);
            end
          end
        end
        BIAS:      state <= WAIT_BIAS;
        WAIT_BIAS: state <= CAPTURE;
        CAPTURE:   state <= OUT;
        OUT: begin
          if (ready_i) begin
            if (out_cnt == CW'(L-1)) begin
              out_cnt <= '0;
              state   <= LOAD;
            end else begin
              out_cnt <= out_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int n = 0; n < L; n++) buffer[n] <= '0;
    end else if (state == CAPTURE) begin
      for (int n = 0; n < L; n++) buffer[n] <= cap[n];
    end
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl (H=4, L=3); expectations follow FC_LAYER_CTRL_RELU_EN.
module tb_fc_layer_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_i;
  logic [15:0] neuron_data_o;
  logic [2:0]  mem_addr_o;
  logic        sum_en_o;
  logic        add_bias_o;
  logic [47:0] neuron_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] data_o;

  int n_chk  = 0;
  int n_pass = 0;

  fc_layer_ctrl #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4), .LAYER_HEIGHT(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .neuron_data_o(neuron_data_o), .mem_addr_o(mem_addr_o),
    .sum_en_o(sum_en_o), .add_bias_o(add_bias_o), .neuron_data_i(neuron_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, ready_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_sum_en"}, sum_en_o, 0);
    check({tag, "_add_bias"}, add_bias_o, 0);
    check({tag, "_nd"}, neuron_data_o, 0);
    check({tag, "_data"}, data_o, 0);
  endtask

  // Entered in the first LOAD cycle; returns in the first LOAD cycle after the last output.
  task automatic do_vector(input logic [15:0] w [4], input logic [31:0] vpat, input int stall_len,
                           input logic [15:0] exp [3], input bit offer_next, input logic [15:0] next_w0);
    int k = 0;
    int i = 0;
    bit prev_hs = 0;
    logic [15:0] prev_w = 0;
    while (k < 4 && i < 40) begin
      check("load_ready", ready_o, 1);
      check("load_addr", mem_addr_o, k);
      check("load_sum_en", sum_en_o, prev_hs);
      check("load_add_bias", add_bias_o, 0);
      check("load_valid", valid_o, 0);
      if (prev_hs) check("load_nd", neuron_data_o, prev_w);
      valid_i = (i < 32) ? vpat[i] : 1'b1;
      data_i  = w[k];
      step();
      prev_hs = valid_i;
      if (valid_i) begin
        prev_w = w[k];
        k++;
      end
      i++;
    end
    valid_i = 0;
    data_i  = 0;
    if (k < 4) check("load_timeout", k, 4);
    check("bias_ready", ready_o, 0);
    check("bias_addr", mem_addr_o, 4);
    check("bias_sum_en", sum_en_o, 1);
    check("bias_nd", neuron_data_o, prev_w);
    check("bias_add_bias", add_bias_o, 0);
    step();
    check("wb_add_bias", add_bias_o, 1);
    check("wb_sum_en", sum_en_o, 0);
    check("wb_nd", neuron_data_o, 0);
    check("wb_addr", mem_addr_o, 0);
    check("wb_ready", ready_o, 0);
    step();
    check("cap_add_bias", add_bias_o, 0);
    check("cap_valid", valid_o, 0);
    check("cap_ready", ready_o, 0);
    step();
    for (int j = 0; j < 3; j++) begin
      if (j == 0) begin
        for (int s = 0; s < stall_len; s++) begin
          ready_i = 0;
          check("stall_valid", valid_o, 1);
          check("stall_data", data_o, exp[0]);
          check("stall_ready", ready_o, 0);
          step();
        end
      end
      ready_i = 1;
      if (offer_next) begin
        valid_i = 1;
        data_i  = next_w0;
      end
      check("out_valid", valid_o, 1);
      check("out_data", data_o, exp[j]);
      check("out_ready", ready_o, 0);
      check("out_sum_en", sum_en_o, 0);
      check("out_addr", mem_addr_o, 0);
      step();
    end
    check("after_ready", ready_o, 1);
    check("after_valid", valid_o, 0);
  endtask

  logic [15:0] wa [4];
  logic [15:0] wb [4];
  logic [15:0] e_basic [3];
  logic [15:0] e_relu [3];

  initial begin
    wa = '{16'd1, 16'd2, 16'd3, 16'd4};
    wb = '{16'd5, 16'd6, 16'd7, 16'd8};
    e_basic = '{16'd10, 16'd20, 16'd30};
`ifdef FC_LAYER_CTRL_RELU_EN
    e_relu = '{16'h0000, 16'h0007, 16'h0000};
`else
    e_relu = '{16'hFFFB, 16'h0007, 16'hFFFF};
`endif
    reset_i = 0;
    valid_i = 0;
    data_i  = 0;
    ready_i = 1;
    neuron_data_i = {16'd30, 16'd20, 16'd10};
    #12;
    check_all_zero("reset");
    step();
    reset_i = 1;
    check("idle_ready", ready_o, 0);
    step();

    // basic vector, back-to-back beats
    do_vector(wa, 32'hFFFF_FFFF, 0, e_basic, 0, 16'd0);
    // input bubbles 1,0,0,1,1,0,1
    do_vector(wa, 32'hFFFF_FF80 | 32'b1011001, 0, e_basic, 0, 16'd0);
    // output backpressure for 5 cycles
    do_vector(wa, 32'hFFFF_FFFF, 5, e_basic, 0, 16'd0);

    // reset after beat 2
    valid_i = 1;
    data_i  = 16'd1;
    step();
    data_i  = 16'd2;
    step();
    reset_i = 0;
    #1;
    check_all_zero("midreset");
    valid_i = 0;
    data_i  = 0;
    step();
    step();
    reset_i = 1;
    check("idle2_ready", ready_o, 0);
    step();
    do_vector(wa, 32'hFFFF_FFFF, 0, e_basic, 0, 16'd0);

    // negative neuron outputs, with the next vector offered during OUT
    neuron_data_i = {16'hFFFF, 16'h0007, 16'hFFFB};
    do_vector(wa, 32'hFFFF_FFFF, 0, e_relu, 1, wb[0]);
    neuron_data_i = {16'd30, 16'd20, 16'd10};
    do_vector(wb, 32'hFFFF_FFFF, 0, e_basic, 0, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fc_layer_ctrl.md
Name: fc_layer_ctrl

Overview:
- Sequencer for one fully-connected layer. Accepts one input vector of PREVIOUS_LAYER_HEIGHT words, one word per valid/ready beat.
- Broadcasts each word to LAYER_HEIGHT fc_neuron instances, together with their ROM address, sum_en and add_bias controls.
- After the bias step, captures all neuron outputs in parallel and streams them downstream serially with valid/ready.
- Sits between the previous layer's output stream and the fc_neuron array.

Parameters:
- WORD_SIZE, 16: data word width, signed.
- PREVIOUS_LAYER_HEIGHT, 4: words per input vector (H); must be >= 1.
- LAYER_HEIGHT, 3: neurons in this layer (L); must be >= 1.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream word valid.
- ready_o  out  1  controller accepts a word this cycle.
- data_i  in  WORD_SIZE  upstream signed word.
- neuron_data_o  out  WORD_SIZE  registered broadcast word to all neurons.
- mem_addr_o  out  $clog2(H+1)  ROM address broadcast to all neurons.
- sum_en_o  out  1  registered accumulate strobe.
- add_bias_o  out  1  registered bias strobe.
- neuron_data_i  in  L*WORD_SIZE  neuron outputs; neuron n occupies bits [n*WORD_SIZE +: WORD_SIZE].
- valid_o  out  1  downstream word valid.
- ready_i  in  1  downstream ready.
- data_o  out  WORD_SIZE  downstream signed word.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - state=IDLE; in_cnt=0, out_cnt=0.
  - neuron_data_o=0, sum_en_o=0, add_bias_o=0, capture buffer all 0.
  - ready_o=0, valid_o=0, mem_addr_o=0, data_o=0.
  - A mid-operation reset abandons the vector; no partial output is emitted.
- State machine: IDLE -> LOAD -> BIAS -> WAIT_BIAS -> CAPTURE -> OUT -> LOAD.
- IDLE: exits to LOAD on the first clock after reset release.
- LOAD:
  - ready_o=1; mem_addr_o=in_cnt (combinational).
  - Handshake = valid_i & ready_o in cycle t. Then in cycle t+1: neuron_data_o=data_i, sum_en_o=1; in_cnt increments.
  - No handshake in cycle t: sum_en_o=0 in t+1, neuron_data_o holds; bubbles are legal.
  - Handshake with in_cnt==H-1: in_cnt returns to 0 and state goes to BIAS.
- BIAS (1 cycle, t+1): ready_o=0; mem_addr_o=H. The last beat's sum_en_o=1 is coincident.
- WAIT_BIAS (1 cycle, t+2): add_bias_o=1, sum_en_o=0, neuron_data_o=0, mem_addr_o=0.
- CAPTURE (1 cycle, t+3): buffer[n] <= neuron_data_i slice n for all n on the closing edge.
- OUT:
  - valid_o=1 from t+4; data_o=buffer[out_cnt].
  - On valid_o & ready_i: out_cnt increments. At out_cnt==L-1 the counter wraps to 0 and state returns to LOAD.
  - data_o holds stable while ready_i=0.
- ready_o=0 in every state except LOAD. Input and output never overlap, so each vector is fully drained before the next is accepted.
- sum_en_o and add_bias_o are never high in the same cycle. Each is high only in the cycles defined above.
- mem_addr_o=0 in every state except LOAD and BIAS.
- Minimum vector period: H accept cycles + 3 + L output cycles.
- Width rules: no arithmetic on data; words pass through unchanged except under RELU_EN. Counters are sized $clog2(H+1) and $clog2(L+1).
- Neuron contract: each neuron restarts its accumulation on the first sum_en after an add_bias.

Optional Feature:
- Macro: FC_LAYER_CTRL_RELU_EN.
- Defined: CAPTURE stores max(slice, 0); a slice with its sign bit set is stored as 0. The buffer, and therefore data_o, is never negative.
- Undefined: slices are stored unmodified, signed values included.

Test Plan:
- Basic vector, H=4, L=3, ready_i=1: feed 1,2,3,4 back-to-back from cycle 2 (beats in cycles 2-5).
  - mem_addr_o = 0,1,2,3 in cycles 2-5, then 4 in cycle 6.
  - sum_en_o high in cycles 3-6 with neuron_data_o = 1,2,3,4; add_bias_o high in cycle 7 only.
  - Stub neuron_data_i={16'd30,16'd20,16'd10}: data_o = 10,20,30 in cycles 9-11, then ready_o=1 in cycle 12.
- Input bubbles: valid_i pattern 1,0,0,1,1,0,1.
  - sum_en_o mirrors each accepted beat one cycle later.
  - mem_addr_o advances only on handshakes; the bias step follows only the 4th beat.
- Output backpressure: ready_i=0 for 5 cycles during OUT.
  - valid_o stays 1 and data_o holds 10; ready_o stays 0.
  - Release produces the 20,30 sequence.
- Reset mid-vector: assert reset_i=0 after beat 2.
  - All outputs go to 0 immediately.
  - A full new vector then produces outputs identical to the basic-vector test.
- RELU_EN: neuron_data_i slices = -5, 7, -1 (0xFFFB, 0x0007, 0xFFFF).
  - Macro defined: data_o = 0, 7, 0.
  - Macro undefined: data_o = 0xFFFB, 0x0007, 0xFFFF.
- Back-to-back vectors: a second vector is offered during OUT.
  - ready_o stays 0 until the last output handshake.
  - The second vector is accepted starting in the next cycle, and its outputs are correct.
